run_sequencer: RTL and testbench

Session controller that wraps the single-cycle core and shares its data memory with a host. It holds the core in reset while the host preloads `dat_mem`, then releases the core and hands it the memory port. It counts execution cycles, detects the core's `done` or a timeout, and re-freezes the core so the host can read results back. It sits between the testbench or host and `top_level`, and owns the `dat_mem` port mux.

---
 rtl/run_pkg.sv | 26 ++
 rtl/run_sequencer_if.sv | 55 +++++
 rtl/run_sequencer_cycle_counter.sv | 30 +++
 rtl/run_sequencer.sv | 148 ++++++++++++++
 tb/tb_run_sequencer.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/run_pkg.sv
`default_nettype none
// ============================================================================
// Module      : run_pkg
// Description : Shared types and default widths for the run sequencer slice.
// Revision    : 1.0 - initial release
// ============================================================================
package run_pkg;

  localparam int DEF_AW = 8;
  localparam int DEF_DW = 8;
  localparam int DEF_CW = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } run_state_t;

  // The host owns the memory port (readback) only while the core is parked.
  function automatic logic is_host_side(input run_state_t s);
    return (s == IDLE) || (s == DONE);
  endfunction

endpackage
`default_nettype wire

// File: rtl/run_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : run_sequencer_if
// Description : Host, core and data-memory signals of the run sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface run_sequencer_if
  import run_pkg::*;
#(
  parameter int AW = DEF_AW,
  parameter int DW = DEF_DW,
  parameter int CW = DEF_CW
);

  logic          start;
  logic          ld_valid;
  logic          ld_ready;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_data;
  logic          ld_last;
  logic          rd_req;
  logic [AW-1:0] rd_addr;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic          core_reset;
  logic          core_done;
  logic          core_we;
  logic [AW-1:0] core_addr;
  logic [DW-1:0] core_wdata;
  logic [DW-1:0] core_rdata;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          busy;
  logic          finished;
  logic          timeout;
  logic [CW-1:0] cycles;

  modport master (
    output start, ld_valid, ld_addr, ld_data, ld_last, rd_req, rd_addr,
           core_done, core_we, core_addr, core_wdata, mem_rdata,
    input  ld_ready, rd_valid, rd_data, core_reset, core_rdata,
           mem_we, mem_addr, mem_wdata, busy, finished, timeout, cycles
  );

  modport slave (
    input  start, ld_valid, ld_addr, ld_data, ld_last, rd_req, rd_addr,
           core_done, core_we, core_addr, core_wdata, mem_rdata,
    output ld_ready, rd_valid, rd_data, core_reset, core_rdata,
           mem_we, mem_addr, mem_wdata, busy, finished, timeout, cycles
  );

endinterface
`default_nettype wire

// File: rtl/run_sequencer_cycle_counter.sv
`default_nettype none
// ============================================================================
// Module      : cycle_counter
// Description : CW-wide saturating cycle counter with synchronous clear.
// Revision    : 1.0 - initial release
// ============================================================================
module cycle_counter #(
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_i,
  input  logic          en_i,
  output logic [CW-1:0] count_o
);

  logic [CW-1:0] count_q;

  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      count_q <= '0;
    end else if (en_i && (count_q != {CW{1'b1}})) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/run_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : run_sequencer
// Description : Session FSM (IDLE/LOAD/RUN/DONE) and dat_mem port mux between
//               host preload/readback and the single-cycle core.
// Revision    : 1.0 - initial release
// ============================================================================
module run_sequencer
  import run_pkg::*;
#(
  parameter int AW      = DEF_AW,
  parameter int DW      = DEF_DW,
  parameter int CW      = DEF_CW,
  parameter int MAX_CYC = 4000
) (
  input  logic          clk,
  input  logic          reset,
  run_sequencer_if.slave bus
);

  localparam logic [CW-1:0] C_LIMIT = CW'(MAX_CYC - 1);

  run_state_t    state_q;
  logic          core_reset_q;
  logic          ld_ready_q;
  logic          busy_q;
  logic          finished_q;
  logic          timeout_q;
  logic          rd_valid_q;
  logic [DW-1:0] rd_data_q;
  logic [CW-1:0] cycles_q;

  logic          in_run;
  logic          host_side;
  logic          done_hit;
  logic          limit_hit;
  logic          cnt_clr;
  logic          cnt_en;

  logic          mem_we_mux;
  logic [AW-1:0] mem_addr_mux;
  logic [DW-1:0] mem_wdata_mux;
  logic [DW-1:0] core_rdata_mux;

  assign in_run    = (state_q == RUN);
  assign host_side = is_host_side(state_q);

  // A done seen while cycles==0 is stale from the core's reset PC.
  assign done_hit  = in_run && bus.core_done && (cycles_q != '0);
  assign limit_hit = in_run && (cycles_q == C_LIMIT);

  // The completing cycle counts on done, but a timeout freezes at MAX_CYC-1.
  assign cnt_en  = in_run && (done_hit || !limit_hit);
  assign cnt_clr = ((state_q == LOAD) && bus.ld_valid && bus.ld_last) ||
                   ((state_q == DONE) && bus.start);

  cycle_counter #(
    .CW (CW)
  ) u_cycle_counter (
    .clk     (clk),
    .rst     (reset),
    .clr_i   (cnt_clr),
    .en_i    (cnt_en),
    .count_o (cycles_q)
  );

  always_comb begin
    mem_we_mux     = 1'b0;
    mem_addr_mux   = bus.rd_addr;
    mem_wdata_mux  = '0;
    core_rdata_mux = '0;
    case (state_q)
      LOAD: begin
        mem_we_mux    = bus.ld_valid;
        mem_addr_mux  = bus.ld_addr;
        mem_wdata_mux = bus.ld_data;
      end
      RUN: begin
        mem_we_mux     = bus.core_we;
        mem_addr_mux   = bus.core_addr;
        mem_wdata_mux  = bus.core_wdata;
        core_rdata_mux = bus.mem_rdata;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      core_reset_q <= 1'b1;
      ld_ready_q   <= 1'b0;
      busy_q       <= 1'b0;
      finished_q   <= 1'b0;
      timeout_q    <= 1'b0;
      rd_valid_q   <= 1'b0;
      rd_data_q    <= '0;
    end else begin
      rd_valid_q <= host_side && bus.rd_req;
      if (host_side && bus.rd_req) begin
        rd_data_q <= bus.mem_rdata;
      end
      case (state_q)
        IDLE, DONE: begin
          if (bus.start) begin
            state_q    <= LOAD;
            ld_ready_q <= 1'b1;
            busy_q     <= 1'b1;
            finished_q <= 1'b0;
            timeout_q  <= 1'b0;
          end
        end
        LOAD: begin
          if (bus.ld_valid && bus.ld_last) begin
            state_q      <= RUN;
            ld_ready_q   <= 1'b0;
            core_reset_q <= 1'b0;
          end
        end
        RUN: begin
          if (done_hit || limit_hit) begin
            state_q      <= DONE;
            core_reset_q <= 1'b1;
            busy_q       <= 1'b0;
            finished_q   <= 1'b1;
            timeout_q    <= !done_hit;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.ld_ready   = ld_ready_q;
  assign bus.rd_valid   = rd_valid_q;
  assign bus.rd_data    = rd_data_q;
  assign bus.core_reset = core_reset_q;
  assign bus.core_rdata = core_rdata_mux;
  assign bus.mem_we     = mem_we_mux;
  assign bus.mem_addr   = mem_addr_mux;
  assign bus.mem_wdata  = mem_wdata_mux;
  assign bus.busy       = busy_q;
  assign bus.finished   = finished_q;
  assign bus.timeout    = timeout_q;
  assign bus.cycles     = cycles_q;

endmodule
`default_nettype wire

// File: tb/tb_run_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_run_sequencer
// Description : Randomized self-checking bench; plays host, core and dat_mem.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_run_sequencer;

  localparam int AW      = 8;
  localparam int DW      = 8;
  localparam int CW      = 16;
  localparam int MAX_CYC = 50;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  run_sequencer_if #(.AW(AW), .DW(DW), .CW(CW)) bus ();

  run_sequencer #(
    .AW      (AW),
    .DW      (DW),
    .CW      (CW),
    .MAX_CYC (MAX_CYC)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // dat_mem: combinational read, write on the rising edge
  logic [DW-1:0] dat_mem [256];
  logic [DW-1:0] ref_mem [256];

  always @(posedge clk) if (bus.mem_we) dat_mem[bus.mem_addr] <= bus.mem_wdata;
  assign bus.mem_rdata = dat_mem[bus.mem_addr];

  int n_chk  = 0;
  int n_fail = 0;

  logic [AW-1:0] beat_a[$];
  logic [DW-1:0] beat_d[$];
  logic [AW-1:0] rb_a[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet_inputs();
    bus.start = 1'b0; bus.ld_valid = 1'b0; bus.ld_addr = '0; bus.ld_data = '0;
    bus.ld_last = 1'b0; bus.rd_req = 1'b0; bus.rd_addr = '0; bus.core_done = 1'b0;
    bus.core_we = 1'b0; bus.core_addr = '0; bus.core_wdata = '0;
  endtask

  task automatic check_load_entry();
    check("load_ld_ready",   bus.ld_ready,   1);
    check("load_busy",       bus.busy,       1);
    check("load_finished",   bus.finished,   0);
    check("load_timeout",    bus.timeout,    0);
    check("load_cycles",     bus.cycles,     0);
    check("load_core_reset", bus.core_reset, 1);
  endtask

  task automatic start_session();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    check_load_entry();
  endtask

  task automatic random_beats(input int n);
    beat_a = {};
    beat_d = {};
    for (int i = 0; i < n; i++) begin
      beat_a.push_back(AW'($urandom));
      beat_d.push_back(DW'($urandom));
    end
  endtask

  task automatic load_beats(input bit spurious);
    if (spurious) begin
      bus.ld_valid   = 1'b0;
      bus.core_we    = 1'b1;
      bus.core_addr  = 8'h20;
      bus.core_wdata = ~ref_mem[8'h20];
      #3;
      check("load_core_write_dropped", bus.mem_we, 0);
      step();
      bus.core_we = 1'b0;
    end
    foreach (beat_a[i]) begin
      bus.ld_valid = 1'b1;
      bus.ld_addr  = beat_a[i];
      bus.ld_data  = beat_d[i];
      bus.ld_last  = (i == beat_a.size() - 1);
      ref_mem[beat_a[i]] = beat_d[i];
      #3;
      check("load_beat_ready", bus.ld_ready, 1);
      check("load_beat_core_reset", bus.core_reset, 1);
      step();
    end
    bus.ld_valid = 1'b0;
    bus.ld_last  = 1'b0;
    check("run_core_reset_low", bus.core_reset, 0);
    check("run_busy",           bus.busy,       1);
    check("run_ld_ready",       bus.ld_ready,   0);
    check("run_cycles_start",   bus.cycles,     0);
  endtask

  // done_at: RUN cycle (1-based) in which core_done is raised, 0 = never
  task automatic run_phase(input int done_at, input bit early_done, input bit poke);
    int  fin_j   = 0;
    bit  by_done = 1'b0;
    for (int j = 1; j <= MAX_CYC; j++) begin
      check("run_cycles_count", bus.cycles, j - 1);
      bus.core_done = (j == done_at) || (early_done && j == 1);
      if (poke) begin
        bus.core_we    = 1'($urandom_range(0, 1));
        bus.core_addr  = AW'($urandom);
        bus.core_wdata = DW'($urandom);
        bus.rd_req     = 1'($urandom_range(0, 1));
        bus.rd_addr    = AW'($urandom);
      end
      #3;
      check("run_core_rdata", bus.core_rdata, ref_mem[bus.core_addr]);
      check("run_mem_we", bus.mem_we, bus.core_we);
      if (bus.core_we) ref_mem[bus.core_addr] = bus.core_wdata;
      by_done = bus.core_done && (j >= 2);
      fin_j   = j;
      step();
      check("run_rd_valid_blocked", bus.rd_valid, 0);
      if (by_done || j == MAX_CYC) break;
    end
    quiet_inputs();
    check("done_finished",   bus.finished,   1);
    check("done_timeout",    bus.timeout,    by_done ? 0 : 1);
    check("done_cycles",     bus.cycles,     by_done ? fin_j : MAX_CYC - 1);
    check("done_core_reset", bus.core_reset, 1);
    check("done_busy",       bus.busy,       0);
  endtask

  // with_start: raise start alongside the final read request
  task automatic readback(input bit with_start);
    foreach (rb_a[i]) begin
      bus.rd_req     = 1'b1;
      bus.rd_addr    = rb_a[i];
      bus.core_we    = 1'b1;
      bus.core_addr  = AW'($urandom);
      bus.core_wdata = DW'($urandom);
      bus.start      = with_start && (i == rb_a.size() - 1);
      #3;
      check("rb_mem_we_idle", bus.mem_we, 0);
      check("rb_core_rdata", bus.core_rdata, 0);
      step();
      check("rb_valid", bus.rd_valid, 1);
      check("rb_data", bus.rd_data, ref_mem[rb_a[i]]);
    end
    quiet_inputs();
    if (with_start) begin
      check_load_entry();
    end else begin
      step();
      check("rb_valid_drop", bus.rd_valid, 0);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      logic [DW-1:0] v;
      v = DW'($urandom);
      dat_mem[i] = v;
      ref_mem[i] = v;
    end
    quiet_inputs();
    reset = 1'b1;
    step();
    step();
    check("rst_core_reset", bus.core_reset, 1);
    check("rst_ld_ready",   bus.ld_ready,   0);
    check("rst_rd_valid",   bus.rd_valid,   0);
    check("rst_rd_data",    bus.rd_data,    0);
    check("rst_mem_we",     bus.mem_we,     0);
    check("rst_busy",       bus.busy,       0);
    check("rst_finished",   bus.finished,   0);
    check("rst_timeout",    bus.timeout,    0);
    check("rst_cycles",     bus.cycles,     0);
    check("rst_core_rdata", bus.core_rdata, 0);
    reset = 1'b0;
    step();

    // Directed preload, stale early done, completion after 40 RUN cycles
    start_session();
    beat_a = '{8'h10, 8'h11, 8'h12};
    beat_d = '{8'hAA, 8'hBB, 8'hCC};
    load_beats(1'b1);
    run_phase(40, 1'b1, 1'b0);
    rb_a = '{8'h10, 8'h11, 8'h12, 8'h20};
    readback(1'b0);
    check("mem_0x10", dat_mem[8'h10], 8'hAA);
    check("mem_0x12", dat_mem[8'h12], 8'hCC);

    // Timeout with core_done never raised, random core traffic
    start_session();
    random_beats(2);
    load_beats(1'b0);
    run_phase(0, 1'b0, 1'b1);
    rb_a = beat_a;
    readback(1'b0);

    // Done in the very last legal cycle beats the timeout
    start_session();
    random_beats(1);
    load_beats(1'b0);
    run_phase(MAX_CYC, 1'b0, 1'b1);

    // Randomized sessions; restart via start+rd_req in DONE on odd rounds
    for (int s = 0; s < 6; s++) begin
      if (s % 2 == 1) begin
        rb_a = {};
        for (int k = 0; k < 3; k++) rb_a.push_back(AW'($urandom));
        readback(1'b1);
      end else begin
        start_session();
      end
      random_beats($urandom_range(1, 4));
      load_beats(1'($urandom_range(0, 1)));
      run_phase($urandom_range(2, MAX_CYC + 8), 1'($urandom_range(0, 1)), 1'b1);
      rb_a = beat_a;
      for (int k = 0; k < 2; k++) rb_a.push_back(AW'($urandom));
      readback(1'b0);
    end

    // Reset in the middle of RUN; start during RUN is ignored
    start_session();
    beat_a = '{8'h30};
    beat_d = '{8'h5A};
    load_beats(1'b0);
    for (int k = 0; k < 10; k++) begin
      bus.start = (k == 3);
      step();
    end
    bus.start = 1'b0;
    check("run_start_ignored", bus.core_reset, 0);
    check("run_cycles_10",     bus.cycles,     10);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("midrst_core_reset", bus.core_reset, 1);
    check("midrst_cycles",     bus.cycles,     0);
    check("midrst_finished",   bus.finished,   0);
    check("midrst_busy",       bus.busy,       0);
    check("midrst_ld_ready",   bus.ld_ready,   0);
    rb_a = '{8'h30, 8'h10};
    readback(1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
